// File: rtl/alu_exec_unit.sv
// EX-stage ALU: AND/OR/ADD/SUB finish in one cycle. MUL runs WIDTH iterations of shift-add
// and holds stall_o high for that whole time.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t             req;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] quick_res, acc_step;
  logic             accept, last_step;

  assign req       = '{op: ALUCtrl_i, a: data1_i, b: data2_i};
  assign ready_o   = (state != S_BUSY);
  assign stall_o   = (state == S_BUSY);
  assign valid_o   = (state == S_DONE);
  assign accept    = start_i && ready_o;
  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Invalid codes fall through to zero so the flag reads as a clean "zero" result.
  always_comb begin
    quick_res = '0;
    case (req.op)
      OP_AND:  quick_res = req.a & req.b;
      OP_OR:   quick_res = req.a | req.b;
      OP_ADD:  quick_res = req.a + req.b;
      OP_SUB:  quick_res = req.a - req.b;
      default: quick_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      data_o <= '0;
      zero_o <= 1'b1;
    end else begin
      case (state)
        S_BUSY: begin
          // Only the low word is kept, so bits shifted past the top of mcand are dropped.
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            data_o <= acc_step;
            zero_o <= (acc_step == '0);
            cnt    <= '0;
            state  <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            if (req.op == OP_MUL) begin
              mcand  <= req.a;
              mplier <= req.b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_BUSY;
            end else begin
              data_o <= quick_res;
              zero_o <= (quick_res == '0);
              state  <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: an arithmetic reference model is checked on every falling edge,
// and directed vectors are checked against hand-computed literals.
module tb_alu_exec_unit;
  localparam int WIDTH = 32;
  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, SUB_ = 3'b110, MUL_ = 3'b011;

  logic             clk, rst_n, start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             ready, valid, stall, zero;
  logic [WIDTH-1:0] data;

  int tests = 0, fails = 0;
  int edges, stalls;
  bit chk_en = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .ALUCtrl_i(op),
    .data1_i(a), .data2_i(b), .ready_o(ready), .valid_o(valid),
    .stall_o(stall), .data_o(data), .zero_o(zero)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a multiply just occupies WIDTH cycles and then presents a*b.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (o)
      AND_:    return x & y;
      OR_:     return x | y;
      ADD_:    return x + y;
      SUB_:    return x - y;
      MUL_:    return x * y;
      default: return '0;
    endcase
  endfunction

  int               busy_left;
  logic [WIDTH-1:0] m_data, pend;
  bit               m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= 0;
      m_data    <= '0;
      m_valid   <= 0;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      m_valid   <= (busy_left == 1);
      if (busy_left == 1) m_data <= pend;
    end else if (start) begin
      if (op == MUL_) begin
        pend      <= ref_op(op, a, b);
        busy_left <= WIDTH;
        m_valid   <= 0;
      end else begin
        m_data  <= ref_op(op, a, b);
        m_valid <= 1;
      end
    end else begin
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", ready, busy_left == 0);
      chk("model_stall", stall, busy_left != 0);
      chk("model_valid", valid, m_valid);
      chk("model_data", data, m_data);
      chk("model_zero", zero, m_data == '0);
    end
  end

  task automatic step();
    if (stall) stalls++;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 0;
    edges = 0;
    stalls = 0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    while (!valid && edges < limit) step();
    if (!valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: valid_o never rose within %0d cycles", name, limit);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [WIDTH-1:0] x,
                     input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] exp, input int exp_edges);
    issue(o, x, y);
    wait_valid(name, 200);
    chk({name, "_data"}, data, exp);
    chk({name, "_zero"}, zero, exp == '0);
    chk({name, "_lat"}, edges, exp_edges);
  endtask

  task automatic reset_check(input string name);
    rst_n = 0;
    #2;
    chk({name, "_data"}, data, '0);
    chk({name, "_zero"}, zero, 1);
    chk({name, "_valid"}, valid, 0);
    chk({name, "_stall"}, stall, 0);
    chk({name, "_ready"}, ready, 1);
    @(negedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1; start = 0; op = '0; a = '0; b = '0;
    #1 rst_n = 0;
    #2 chk_en = 1;
    #10 rst_n = 1;
    @(posedge clk);
    #1;

    run("add_wrap", ADD_, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    run("sub_zero", SUB_, 32'd5, 32'd5, 32'h0, 0);
    run("and", AND_, 32'hF0F0, 32'h0FF0, 32'h00F0, 0);
    run("or", OR_, 32'hF000, 32'h000F, 32'hF00F, 0);

    reset_check("rst_idle");

    // MUL 3 x -2 with operand churn and start pulses while busy.
    issue(MUL_, 32'd3, 32'hFFFF_FFFE);
    repeat (6) begin
      start = 1; op = ADD_; a = $urandom; b = $urandom;
      step();
    end
    start = 0;
    wait_valid("mul_neg", 200);
    chk("mul_neg_data", data, 32'hFFFF_FFFA);
    chk("mul_neg_zero", zero, 0);
    chk("mul_neg_stall_cycles", stalls, WIDTH);
    chk("mul_neg_lat", edges, WIDTH);
    step();
    chk("mul_neg_valid_once", valid, 0);

    run("mul_trunc", MUL_, 32'h1_0000, 32'h1_0000, 32'h0, WIDTH);

    issue(MUL_, 32'd7, 32'd9);
    repeat (15) step();
    chk("mul_abort_stall_before", stall, 1);
    reset_check("rst_mid_mul");
    run("add_after_rst", ADD_, 32'd2, 32'd2, 32'd4, 0);

    // Back-to-back issue with start held high.
    start = 1; op = ADD_; a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    chk("b2b_add_valid", valid, 1);
    chk("b2b_add_data", data, 32'd30);
    op = SUB_; a = 32'd10; b = 32'd3;
    @(posedge clk); #1;
    chk("b2b_sub_valid", valid, 1);
    chk("b2b_sub_data", data, 32'd7);
    op = 3'b111; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    chk("b2b_inv_valid", valid, 1);
    chk("b2b_inv_data", data, 32'd0);
    chk("b2b_inv_zero", zero, 1);
    op = MUL_; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    edges = 0; stalls = 0;
    chk("b2b_mul_ready", ready, 0);
    chk("b2b_mul_hold", data, 32'd0);
    wait_valid("b2b_mul", 200);
    chk("b2b_mul_data", data, 32'd42);
    chk("b2b_mul_lat", edges, WIDTH);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
